// File: rtl/game_tick_gen.sv
// -----------------------------------------------------------------------------
// game_tick_gen
//   Step-tick generator feeding GameEngine's 'timer' input. Emits single-cycle
//   pulses every 'period' clocks. Each accepted player drop raises the level,
//   shortens the period (down to a floor), and suppresses ticks for a short
//   settle window. End-of-game freezes generation until reset.
//
// Ports
//   clk      in   1      system clock
//   rstBtn   in   1      synchronous, active-high reset (highest priority)
//   dropBtn  in   1      player drop, pre-conditioned to a 1-cycle pulse
//   EOG      in   1      end-of-game, level-sensitive; latches FROZEN
//   timer    out  1      tick pulse, exactly one cycle high per tick
//   level    out  4      accepted drops since reset, saturating at MAX_LEVEL
//   period   out  CNT_W  current tick period in clocks
// -----------------------------------------------------------------------------
module game_tick_gen #(
    parameter int CNT_W       = 25,
    parameter int BASE_PERIOD = 25_000_000,
    parameter int STEP        = 2_500_000,
    parameter int MIN_PERIOD  = 5_000_000,
    parameter int HOLD_CYCLES = 16,
    parameter int MAX_LEVEL   = 7
) (
    input  logic             clk,
    input  logic             rstBtn,
    input  logic             dropBtn,
    input  logic             EOG,
    output logic             timer,
    output logic [3:0]       level,
    output logic [CNT_W-1:0] period
);

    // Hold counter only needs to represent HOLD_CYCLES-1.
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  BASE_C     = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0]  STEP_C     = CNT_W'(STEP);
    localparam logic [CNT_W-1:0]  MIN_C      = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]  ONE_C      = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [3:0]        MAX_LVL    = 4'(MAX_LEVEL);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HOLD,
        ST_FROZEN
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  period_reg;
    logic [HOLD_W-1:0] hold_reg;
    logic [3:0]        level_reg;
    logic              timer_reg;

    logic              tick_due;
    logic [CNT_W-1:0]  period_next;
    logic [3:0]        level_next;

    assign tick_due = (cnt_reg == period_reg - ONE_C);

    // The 'period < STEP' test guards the subtraction, so a wrapped
    // difference never reaches the comparison result.
    always_comb begin
        period_next = period_reg - STEP_C;
        if ((period_reg < STEP_C) || ((period_reg - STEP_C) < MIN_C)) begin
            period_next = MIN_C;
        end
    end

    always_comb begin
        level_next = level_reg + 4'd1;
        if (level_reg == MAX_LVL) begin
            level_next = level_reg;
        end
    end

    // Priority: reset > EOG > drop > due tick.
    always_ff @(posedge clk) begin
        if (rstBtn) begin
            state_reg  <= ST_RUN;
            cnt_reg    <= '0;
            period_reg <= BASE_C;
            level_reg  <= 4'd0;
            hold_reg   <= '0;
            timer_reg  <= 1'b0;
        end else if (EOG) begin
            state_reg <= ST_FROZEN;
            timer_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (dropBtn) begin
                        // Drop discards any tick due in this same cycle.
                        level_reg  <= level_next;
                        period_reg <= period_next;
                        cnt_reg    <= '0;
                        hold_reg   <= HOLD_INIT;
                        state_reg  <= ST_HOLD;
                        timer_reg  <= 1'b0;
                    end else if (tick_due) begin
                        cnt_reg   <= '0;
                        timer_reg <= 1'b1;
                    end else begin
                        cnt_reg   <= cnt_reg + ONE_C;
                        timer_reg <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    // Settle window: drops are ignored, counter parked at 0.
                    timer_reg <= 1'b0;
                    if (hold_reg == '0) begin
                        state_reg <= ST_RUN;
                        cnt_reg   <= '0;
                    end else begin
                        hold_reg <= hold_reg - HOLD_ONE;
                    end
                end

                ST_FROZEN: begin
                    // Only reset leaves this state.
                    timer_reg <= 1'b0;
                end

                default: begin
                    state_reg <= ST_FROZEN;
                    timer_reg <= 1'b0;
                end
            endcase
        end
    end

    assign timer  = timer_reg;
    assign level  = level_reg;
    assign period = period_reg;

endmodule

// File: tb/tb_game_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_game_tick_gen
//   Self-checking bench for game_tick_gen. The reference model works on
//   absolute cycle timestamps (next tick time, end of settle window, frozen
//   flag) rather than counters and states.
// -----------------------------------------------------------------------------
module tb_game_tick_gen;

    localparam int CW    = 8;
    localparam int BASE  = 6;
    localparam int STEP  = 1;
    localparam int MINP  = 3;
    localparam int HOLD  = 4;
    localparam int MAXL  = 7;

    logic          clk     = 1'b0;
    logic          rstBtn  = 1'b1;
    logic          dropBtn = 1'b0;
    logic          EOG     = 1'b0;
    logic          timer;
    logic [3:0]    level;
    logic [CW-1:0] period;

    always #5 clk = ~clk;

    game_tick_gen #(
        .CNT_W      (CW),
        .BASE_PERIOD(BASE),
        .STEP       (STEP),
        .MIN_PERIOD (MINP),
        .HOLD_CYCLES(HOLD),
        .MAX_LEVEL  (MAXL)
    ) dut (
        .clk    (clk),
        .rstBtn (rstBtn),
        .dropBtn(dropBtn),
        .EOG    (EOG),
        .timer  (timer),
        .level  (level),
        .period (period)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: t is the index of the most recent posedge.
    int t           = 0;
    int m_level     = 0;
    int m_period    = BASE;
    int m_next_tick = 0;
    int m_hold_end  = 0;
    bit m_frozen    = 1'b0;
    bit e_timer     = 1'b0;

    // Advance the model by the upcoming posedge, then clock the DUT and
    // leave time 1 unit past the edge for sampling.
    task automatic step();
        t++;
        e_timer = 1'b0;
        if (rstBtn) begin
            m_level     = 0;
            m_period    = BASE;
            m_frozen    = 1'b0;
            m_next_tick = t + BASE;
            m_hold_end  = t;
        end else if (m_frozen || EOG) begin
            m_frozen = 1'b1;
        end else if (t <= m_hold_end) begin
            e_timer = 1'b0;
        end else if (dropBtn) begin
            m_level     = (m_level < MAXL) ? m_level + 1 : MAXL;
            m_period    = (m_period - STEP < MINP) ? MINP : m_period - STEP;
            m_hold_end  = t + HOLD;
            m_next_tick = t + HOLD + m_period;
        end else if (t == m_next_tick) begin
            e_timer     = 1'b1;
            m_next_tick = t + m_period;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstBtn = 1'b1; dropBtn = 1'b0; EOG = 1'b0;
        step();
        rstBtn = 1'b0;
    endtask

    task automatic test_reset();
        rstBtn = 1'b1; dropBtn = 1'b1; EOG = 1'b1;
        step();
        n_checks++;
        if (timer !== 1'b0) begin
            n_fail++; $display("FAIL reset_timer: got %0b expected 0", timer);
        end
        n_checks++;
        if (level !== 4'd0) begin
            n_fail++; $display("FAIL reset_level: got %0d expected 0", level);
        end
        n_checks++;
        if (period !== CW'(BASE)) begin
            n_fail++; $display("FAIL reset_period: got %0d expected %0d", period, BASE);
        end
        $display("reset: timer=%0b level=%0d period=%0d", timer, level, period);
        rstBtn = 1'b0; dropBtn = 1'b0; EOG = 1'b0;
    endtask

    task automatic test_idle();
        int ticks = 0;
        int last  = -1;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step();
            n_checks++;
            if ({timer, level, period} !== {e_timer, 4'(m_level), CW'(m_period)}) begin
                n_fail++;
                $display("FAIL idle t=%0d: got timer=%0b level=%0d period=%0d, expected timer=%0b level=%0d period=%0d",
                         t, timer, level, period, e_timer, m_level, m_period);
            end
            if (timer === 1'b1) begin
                if (last >= 0) begin
                    n_checks++;
                    if (t - last !== BASE) begin
                        n_fail++; $display("FAIL idle_interval: got %0d expected %0d", t - last, BASE);
                    end
                end
                last = t;
                ticks++;
            end
        end
        n_checks++;
        if (ticks !== 6) begin
            n_fail++; $display("FAIL idle_tick_count: got %0d expected 6", ticks);
        end
        $display("idle: %0d ticks in 40 clk", ticks);
    endtask

    task automatic test_drop();
        int d;
        int last = -1;
        do_reset();
        repeat (3) step();
        dropBtn = 1'b1;
        step();
        dropBtn = 1'b0;
        d = t;
        n_checks++;
        if ({timer, level, period} !== {1'b0, 4'd1, CW'(5)}) begin
            n_fail++;
            $display("FAIL drop_accept: got timer=%0b level=%0d period=%0d, expected timer=0 level=1 period=5",
                     timer, level, period);
        end
        for (int i = 0; i < 25; i++) begin
            step();
            n_checks++;
            if ({timer, level, period} !== {e_timer, 4'(m_level), CW'(m_period)}) begin
                n_fail++;
                $display("FAIL drop t=%0d: got timer=%0b level=%0d period=%0d, expected timer=%0b level=%0d period=%0d",
                         t, timer, level, period, e_timer, m_level, m_period);
            end
            if (timer === 1'b1) begin
                n_checks++;
                if (last < 0 && t - d !== HOLD + 5) begin
                    n_fail++; $display("FAIL drop_first_tick: got %0d clk expected %0d", t - d, HOLD + 5);
                end else if (last >= 0 && t - last !== 5) begin
                    n_fail++; $display("FAIL drop_interval: got %0d expected 5", t - last);
                end
                last = t;
            end
        end
        n_checks++;
        if (last < 0) begin
            n_fail++; $display("FAIL drop_no_tick: got none expected tick within 25 clk");
        end
        $display("drop: level=%0d period=%0d", level, period);
    endtask

    task automatic test_eight_drops();
        int exp_l;
        int exp_p;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            dropBtn = 1'b1;
            step();
            dropBtn = 1'b0;
            exp_l = (i < MAXL) ? i : MAXL;
            exp_p = (BASE - i < MINP) ? MINP : BASE - i;
            n_checks++;
            if (level !== 4'(exp_l) || period !== CW'(exp_p)) begin
                n_fail++;
                $display("FAIL ramp drop%0d: got level=%0d period=%0d expected level=%0d period=%0d",
                         i, level, period, exp_l, exp_p);
            end
            $display("ramp drop%0d: level=%0d period=%0d", i, level, period);
            for (int k = 0; k < 19; k++) begin
                step();
                n_checks++;
                if ({timer, level, period} !== {e_timer, 4'(m_level), CW'(m_period)}) begin
                    n_fail++;
                    $display("FAIL ramp t=%0d: got timer=%0b level=%0d period=%0d, expected timer=%0b level=%0d period=%0d",
                             t, timer, level, period, e_timer, m_level, m_period);
                end
            end
        end
    endtask

    task automatic test_drop_on_tick();
        do_reset();
        repeat (BASE - 1) step();
        dropBtn = 1'b1;               // lands on the posedge where the tick is due
        step();
        dropBtn = 1'b0;
        n_checks++;
        if (timer !== 1'b0 || level !== 4'd1) begin
            n_fail++;
            $display("FAIL drop_on_tick: got timer=%0b level=%0d expected timer=0 level=1", timer, level);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if ({timer, level, period} !== {e_timer, 4'(m_level), CW'(m_period)}) begin
                n_fail++;
                $display("FAIL drop_on_tick t=%0d: got timer=%0b level=%0d period=%0d, expected timer=%0b level=%0d period=%0d",
                         t, timer, level, period, e_timer, m_level, m_period);
            end
        end
        dropBtn = 1'b1;               // held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({timer, level, period} !== {e_timer, 4'(m_level), CW'(m_period)}) begin
                n_fail++;
                $display("FAIL held_drop t=%0d: got timer=%0b level=%0d period=%0d, expected timer=%0b level=%0d period=%0d",
                         t, timer, level, period, e_timer, m_level, m_period);
            end
        end
        dropBtn = 1'b0;
        n_checks++;
        if (level !== 4'd2) begin
            n_fail++; $display("FAIL held_drop_level: got %0d expected 2", level);
        end
        $display("drop_on_tick: level=%0d period=%0d", level, period);
    endtask

    task automatic test_eog_with_drop();
        do_reset();
        repeat (3) step();
        EOG = 1'b1; dropBtn = 1'b1;
        step();
        dropBtn = 1'b0;
        n_checks++;
        if (timer !== 1'b0 || level !== 4'd0 || period !== CW'(BASE)) begin
            n_fail++;
            $display("FAIL eog_drop: got timer=%0b level=%0d period=%0d expected timer=0 level=0 period=%0d",
                     timer, level, period, BASE);
        end
        for (int i = 0; i < 70; i++) begin
            if (i == 50) EOG = 1'b0;
            dropBtn = (i == 60) ? 1'b1 : 1'b0;
            step();
            n_checks++;
            if ({timer, level, period} !== {1'b0, 4'd0, CW'(BASE)} ||
                {timer, level, period} !== {e_timer, 4'(m_level), CW'(m_period)}) begin
                n_fail++;
                $display("FAIL frozen t=%0d: got timer=%0b level=%0d period=%0d, expected timer=0 level=0 period=%0d",
                         t, timer, level, period, BASE);
            end
        end
        dropBtn = 1'b0;
        $display("frozen: timer=%0b level=%0d after 70 clk", timer, level);
    endtask

    task automatic test_reset_mid();
        int r;
        int first;
        do_reset();
        repeat (2) step();
        dropBtn = 1'b1; step(); dropBtn = 1'b0;
        repeat (2) step();
        rstBtn = 1'b1;                // reset while in the settle window
        step();
        rstBtn = 1'b0;
        r = t;
        n_checks++;
        if ({timer, level, period} !== {1'b0, 4'd0, CW'(BASE)}) begin
            n_fail++;
            $display("FAIL reset_in_hold: got timer=%0b level=%0d period=%0d expected timer=0 level=0 period=%0d",
                     timer, level, period, BASE);
        end
        first = -1;
        for (int i = 0; i < 10 && first < 0; i++) begin
            step();
            if (timer === 1'b1) first = t - r;
        end
        n_checks++;
        if (first !== BASE) begin
            n_fail++; $display("FAIL reset_first_tick: got %0d clk expected %0d", first, BASE);
        end
        dropBtn = 1'b1; step(); dropBtn = 1'b0;
        EOG = 1'b1;
        repeat (5) step();
        rstBtn = 1'b1;                // reset beats a still-asserted EOG
        step();
        rstBtn = 1'b0; EOG = 1'b0;
        n_checks++;
        if ({timer, level, period} !== {1'b0, 4'd0, CW'(BASE)}) begin
            n_fail++;
            $display("FAIL reset_in_frozen: got timer=%0b level=%0d period=%0d expected timer=0 level=0 period=%0d",
                     timer, level, period, BASE);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if ({timer, level, period} !== {e_timer, 4'(m_level), CW'(m_period)}) begin
                n_fail++;
                $display("FAIL post_frozen t=%0d: got timer=%0b level=%0d period=%0d, expected timer=%0b level=%0d period=%0d",
                         t, timer, level, period, e_timer, m_level, m_period);
            end
        end
        $display("reset_mid: first tick after release at %0d clk", first);
    endtask

    task automatic test_random();
        int errs_before = n_fail;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rstBtn  = ($urandom_range(0, 149) == 0) || (m_frozen && $urandom_range(0, 19) == 0);
            EOG     = ($urandom_range(0, 249) == 0);
            dropBtn = ($urandom_range(0, 5) == 0);
            step();
            n_checks++;
            if ({timer, level, period} !== {e_timer, 4'(m_level), CW'(m_period)}) begin
                n_fail++;
                $display("FAIL random t=%0d: got timer=%0b level=%0d period=%0d, expected timer=%0b level=%0d period=%0d",
                         t, timer, level, period, e_timer, m_level, m_period);
            end
        end
        rstBtn = 1'b0; EOG = 1'b0; dropBtn = 1'b0;
        $display("random: 3000 clk, %0d new failures", n_fail - errs_before);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_drop();
        test_eight_drops();
        test_drop_on_tick();
        test_eog_with_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
